// File: rtl/friscv_mc_ctrl.sv
// Multi-cycle control FSM for the FRiscV datapath: sequences fetch/decode/execute/memory/writeback
// over a shared memory port, stalling on mem_ready_in and trapping on unsupported instructions.
module friscv_mc_ctrl #(
   parameter int STATE_W    = 4,
   parameter int ALU_CTRL_W = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [6:0]            opcode_in,
   input  logic [2:0]            funct3_in,
   input  logic                  funct7b5_in,
   input  logic                  zero_in,
   input  logic                  mem_ready_in,
   output logic                  pc_write_out,
   output logic                  ir_write_out,
   output logic                  adr_src_out,
   output logic                  mem_write_out,
   output logic                  reg_write_out,
   output logic [1:0]            result_src_out,
   output logic [1:0]            alu_src_a_out,
   output logic [1:0]            alu_src_b_out,
   output logic [1:0]            imm_src_out,
   output logic [ALU_CTRL_W-1:0] alu_ctrl_out,
   output logic                  illegal_out,
   output logic [STATE_W-1:0]    state_out
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10,
      S_TRAP     = 4'd11
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   state_t state_reg;
   state_t state_next;

   logic       is_lw;
   logic       is_sw;
   logic       is_rtype;
   logic       is_itype;
   logic       is_beq;
   logic       is_jal;
   logic       funct3_word;
   logic       funct3_alu_ok;
   logic [2:0] alu_decoded;

   logic       pc_write;
   logic       ir_write;
   logic       adr_src;
   logic       mem_write;
   logic       reg_write;
   logic [1:0] result_src;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] imm_src;
   logic [2:0] alu_ctrl;
   logic       illegal;

   assign is_lw    = (opcode_in == OP_LW);
   assign is_sw    = (opcode_in == OP_SW);
   assign is_rtype = (opcode_in == OP_R);
   assign is_itype = (opcode_in == OP_I);
   assign is_beq   = (opcode_in == OP_BEQ);
   assign is_jal   = (opcode_in == OP_JAL);

   assign funct3_word   = (funct3_in == 3'b010);
   assign funct3_alu_ok = (funct3_in == 3'b000) || (funct3_in == 3'b010) ||
                          (funct3_in == 3'b110) || (funct3_in == 3'b111);

   // funct7b5 only selects sub for register-register ops; addi has no funct7 field.
   always_comb begin
      alu_decoded = ALU_ADD;
      case (funct3_in)
         3'b000:  alu_decoded = (is_rtype && funct7b5_in) ? ALU_SUB : ALU_ADD;
         3'b010:  alu_decoded = ALU_SLT;
         3'b110:  alu_decoded = ALU_OR;
         3'b111:  alu_decoded = ALU_AND;
         default: alu_decoded = ALU_ADD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_FETCH;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      result_src = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      imm_src    = 2'b00;
      alu_ctrl   = ALU_ADD;
      illegal    = 1'b0;

      case (state_reg)
         S_FETCH: begin
            adr_src    = 1'b0;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b10;
            alu_ctrl   = ALU_ADD;
            result_src = 2'b10;
            if (mem_ready_in) begin
               ir_write   = 1'b1;
               pc_write   = 1'b1;
               state_next = S_DECODE;
            end
         end

         S_DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            imm_src   = 2'b10;
            alu_ctrl  = ALU_ADD;
            if ((is_lw || is_sw) && funct3_word) begin
               state_next = S_MEMADR;
            end else if (is_rtype && funct3_alu_ok) begin
               state_next = S_EXECR;
            end else if (is_itype && funct3_alu_ok) begin
               state_next = S_EXECI;
            end else if (is_beq && (funct3_in == 3'b000)) begin
               state_next = S_BEQ;
            end else if (is_jal) begin
               state_next = S_JAL;
            end else begin
               state_next = S_TRAP;
            end
         end

         S_MEMADR: begin
            alu_src_a  = 2'b10;
            alu_src_b  = 2'b01;
            alu_ctrl   = ALU_ADD;
            imm_src    = is_sw ? 2'b01 : 2'b00;
            state_next = is_sw ? S_MEMWRITE : S_MEMREAD;
         end

         S_MEMREAD: begin
            adr_src    = 1'b1;
            result_src = 2'b00;
            if (mem_ready_in) begin
               state_next = S_MEMWB;
            end
         end

         S_MEMWB: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
            state_next = S_FETCH;
         end

         // The write strobe stays up for the whole access; memory commits when it signals ready.
         S_MEMWRITE: begin
            adr_src    = 1'b1;
            result_src = 2'b00;
            mem_write  = 1'b1;
            if (mem_ready_in) begin
               state_next = S_FETCH;
            end
         end

         S_EXECR: begin
            alu_src_a  = 2'b10;
            alu_src_b  = 2'b00;
            alu_ctrl   = alu_decoded;
            state_next = S_ALUWB;
         end

         S_EXECI: begin
            alu_src_a  = 2'b10;
            alu_src_b  = 2'b01;
            imm_src    = 2'b00;
            alu_ctrl   = alu_decoded;
            state_next = S_ALUWB;
         end

         S_ALUWB: begin
            result_src = 2'b00;
            reg_write  = 1'b1;
            state_next = S_FETCH;
         end

         // Branch target was precomputed in DECODE and sits in the ALU-out register.
         S_BEQ: begin
            alu_src_a  = 2'b10;
            alu_src_b  = 2'b00;
            alu_ctrl   = ALU_SUB;
            result_src = 2'b00;
            pc_write   = zero_in;
            state_next = S_FETCH;
         end

         S_JAL: begin
            alu_src_a  = 2'b01;
            alu_src_b  = 2'b10;
            alu_ctrl   = ALU_ADD;
            result_src = 2'b00;
            pc_write   = 1'b1;
            state_next = S_ALUWB;
         end

         S_TRAP: begin
            illegal    = 1'b1;
            state_next = S_TRAP;
         end

         default: begin
            state_next = S_TRAP;
         end
      endcase
   end

   // Strobes are masked during reset so an aborted instruction never commits anything.
   assign pc_write_out   = pc_write  & ~rst;
   assign ir_write_out   = ir_write  & ~rst;
   assign mem_write_out  = mem_write & ~rst;
   assign reg_write_out  = reg_write & ~rst;
   assign illegal_out    = illegal   & ~rst;

   assign adr_src_out    = adr_src;
   assign result_src_out = result_src;
   assign alu_src_a_out  = alu_src_a;
   assign alu_src_b_out  = alu_src_b;
   assign imm_src_out    = imm_src;
   assign alu_ctrl_out   = ALU_CTRL_W'(alu_ctrl);
   assign state_out      = STATE_W'(state_reg);

endmodule

// File: tb/tb_friscv_mc_ctrl.sv
// Bench for friscv_mc_ctrl: builds a per-cycle expectation plan from instruction-level rules
// (stall counts, legality, optional abort) and compares state and all outputs every cycle.
module tb_friscv_mc_ctrl;

   localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3, S_MEMWB = 4;
   localparam int S_MEMWRITE = 5, S_EXECR = 6, S_EXECI = 7, S_ALUWB = 8, S_BEQ = 9;
   localparam int S_JAL = 10, S_TRAP = 11;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   logic       clk;
   logic       rst;
   logic [6:0] opcode_in;
   logic [2:0] funct3_in;
   logic       funct7b5_in;
   logic       zero_in;
   logic       mem_ready_in;
   logic       pc_write_out;
   logic       ir_write_out;
   logic       adr_src_out;
   logic       mem_write_out;
   logic       reg_write_out;
   logic [1:0] result_src_out;
   logic [1:0] alu_src_a_out;
   logic [1:0] alu_src_b_out;
   logic [1:0] imm_src_out;
   logic [2:0] alu_ctrl_out;
   logic       illegal_out;
   logic [3:0] state_out;

   friscv_mc_ctrl #(.STATE_W(4), .ALU_CTRL_W(3)) dut (
      .clk            (clk),
      .rst            (rst),
      .opcode_in      (opcode_in),
      .funct3_in      (funct3_in),
      .funct7b5_in    (funct7b5_in),
      .zero_in        (zero_in),
      .mem_ready_in   (mem_ready_in),
      .pc_write_out   (pc_write_out),
      .ir_write_out   (ir_write_out),
      .adr_src_out    (adr_src_out),
      .mem_write_out  (mem_write_out),
      .reg_write_out  (reg_write_out),
      .result_src_out (result_src_out),
      .alu_src_a_out  (alu_src_a_out),
      .alu_src_b_out  (alu_src_b_out),
      .imm_src_out    (imm_src_out),
      .alu_ctrl_out   (alu_ctrl_out),
      .illegal_out    (illegal_out),
      .state_out      (state_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         st;
      bit         rdy;
      bit         z;
      bit         r;
      bit         first;
      logic [6:0] op;
      logic [2:0] f3;
      bit         f7;
   } step_t;

   step_t plan[$];
   int    n_tests = 0;
   int    n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit legal_instr(input logic [6:0] op, input logic [2:0] f3);
      bit alu_ok;
      alu_ok = (f3 == 3'd0) || (f3 == 3'd2) || (f3 == 3'd6) || (f3 == 3'd7);
      if (op == OP_LW || op == OP_SW) return f3 == 3'd2;
      if (op == OP_R || op == OP_I)   return alu_ok;
      if (op == OP_BEQ)               return f3 == 3'd0;
      if (op == OP_JAL)               return 1'b1;
      return 1'b0;
   endfunction

   // Packed as {pc_w, ir_w, adr, mem_w, reg_w, result[2], src_a[2], src_b[2], imm[2], alu[3], illegal}
   function automatic logic [16:0] exp_out(input step_t s);
      logic pcw, irw, adr, mw, rw, ill;
      logic [1:0] res, a, b, imm;
      logic [2:0] alu, aluop;
      pcw = 0; irw = 0; adr = 0; mw = 0; rw = 0; ill = 0;
      res = 0; a = 0; b = 0; imm = 0; alu = 0;
      case (s.f3)
         3'd0:    aluop = (s.op == OP_R && s.f7) ? 3'b001 : 3'b000;
         3'd2:    aluop = 3'b101;
         3'd6:    aluop = 3'b011;
         3'd7:    aluop = 3'b010;
         default: aluop = 3'b000;
      endcase
      case (s.st)
         S_FETCH:    begin b = 2'b10; res = 2'b10; pcw = s.rdy; irw = s.rdy; end
         S_DECODE:   begin a = 2'b01; b = 2'b01; imm = 2'b10; end
         S_MEMADR:   begin a = 2'b10; b = 2'b01; imm = (s.op == OP_SW) ? 2'b01 : 2'b00; end
         S_MEMREAD:  begin adr = 1; end
         S_MEMWB:    begin res = 2'b01; rw = 1; end
         S_MEMWRITE: begin adr = 1; mw = 1; end
         S_EXECR:    begin a = 2'b10; alu = aluop; end
         S_EXECI:    begin a = 2'b10; b = 2'b01; alu = aluop; end
         S_ALUWB:    begin rw = 1; end
         S_BEQ:      begin a = 2'b10; alu = 3'b001; pcw = s.z; end
         S_JAL:      begin a = 2'b01; b = 2'b10; pcw = 1; end
         S_TRAP:     begin ill = 1; end
         default:    begin end
      endcase
      if (s.r) begin
         pcw = 0; irw = 0; mw = 0; rw = 0; ill = 0;
      end
      return {pcw, irw, adr, mw, rw, res, a, b, imm, alu, ill};
   endfunction

   function automatic bit pick_z(input int zf);
      if (zf < 0) return 1'($urandom_range(0, 1));
      return zf[0];
   endfunction

   // fs/ms: wait cycles in FETCH and in the memory state; abort_at: step index hit by reset (-1 none);
   // zf: forced zero flag (-1 random); tn: cycles spent in TRAP before a reset clears it.
   task automatic add_instr(input logic [6:0] op, input logic [2:0] f3, input bit f7,
                            input int fs, input int ms, input int abort_at, input int zf, input int tn);
      step_t tmp[$];
      step_t s;
      s.op = op; s.f3 = f3; s.f7 = f7; s.r = 0; s.first = 0; s.z = 0;
      for (int i = 0; i < fs; i++) begin
         s.st = S_FETCH; s.rdy = 0; s.z = pick_z(zf); tmp.push_back(s);
      end
      s.st = S_FETCH; s.rdy = 1; s.z = pick_z(zf); tmp.push_back(s);
      s.st = S_DECODE; s.rdy = 1'($urandom_range(0, 1)); s.z = pick_z(zf); tmp.push_back(s);
      if (!legal_instr(op, f3)) begin
         for (int i = 0; i < tn; i++) begin
            s.st = S_TRAP; s.rdy = 1'($urandom_range(0, 1)); s.z = pick_z(zf); tmp.push_back(s);
         end
         s.st = S_TRAP; s.r = 1; tmp.push_back(s);
         s.r = 0;
      end else if (op == OP_LW || op == OP_SW) begin
         s.st = S_MEMADR; s.rdy = 1'($urandom_range(0, 1)); s.z = pick_z(zf); tmp.push_back(s);
         for (int i = 0; i < ms; i++) begin
            s.st = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE; s.rdy = 0; s.z = pick_z(zf);
            tmp.push_back(s);
         end
         s.st = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE; s.rdy = 1; s.z = pick_z(zf); tmp.push_back(s);
         if (op == OP_LW) begin
            s.st = S_MEMWB; s.rdy = 1'($urandom_range(0, 1)); s.z = pick_z(zf); tmp.push_back(s);
         end
      end else begin
         case (op)
            OP_R:    s.st = S_EXECR;
            OP_I:    s.st = S_EXECI;
            OP_BEQ:  s.st = S_BEQ;
            default: s.st = S_JAL;
         endcase
         s.rdy = 1'($urandom_range(0, 1)); s.z = pick_z(zf); tmp.push_back(s);
         if (op != OP_BEQ) begin
            s.st = S_ALUWB; s.rdy = 1'($urandom_range(0, 1)); s.z = pick_z(zf); tmp.push_back(s);
         end
      end
      for (int i = 0; i < tmp.size(); i++) begin
         s = tmp[i];
         s.first = (i == 0);
         if (i == abort_at) s.r = 1;
         plan.push_back(s);
         if (i == abort_at) break;
      end
   endtask

   initial begin
      step_t s;
      logic [6:0] op;
      logic [2:0] f3;
      logic [16:0] got;
      int kind, abort_at, n_instr;

      rst = 1; opcode_in = 0; funct3_in = 0; funct7b5_in = 0; zero_in = 0; mem_ready_in = 0;

      // Two reset cycles in FETCH with ready high: strobes must stay masked.
      s.st = S_FETCH; s.rdy = 1; s.z = 0; s.r = 1; s.first = 0; s.op = OP_R; s.f3 = 0; s.f7 = 0;
      plan.push_back(s);
      plan.push_back(s);

      add_instr(OP_R,   3'd0, 1'b1, 0, 0, -1, -1, 0);
      add_instr(OP_LW,  3'd2, 1'b0, 2, 3, -1, -1, 0);
      add_instr(OP_SW,  3'd2, 1'b0, 0, 0, -1, -1, 0);
      add_instr(OP_BEQ, 3'd0, 1'b0, 0, 0, -1,  1, 0);
      add_instr(OP_BEQ, 3'd0, 1'b0, 0, 0, -1,  0, 0);
      add_instr(OP_JAL, 3'd5, 1'b1, 0, 0, -1, -1, 0);
      add_instr(OP_I,   3'd0, 1'b1, 0, 0, -1, -1, 0);
      add_instr(7'b0001111, 3'd0, 1'b0, 0, 0, -1, -1, 20);
      add_instr(OP_SW,  3'd2, 1'b0, 0, 2, 3, -1, 0);
      add_instr(OP_R,   3'd1, 1'b0, 1, 0, -1, -1, 2);

      for (int n = 0; n < 200; n++) begin
         kind = int'($urandom_range(0, 7));
         case (kind)
            0: op = OP_LW;
            1: op = OP_SW;
            2: op = OP_R;
            3: op = OP_I;
            4: op = OP_BEQ;
            5: op = OP_JAL;
            6: op = 7'($urandom_range(0, 127));
            default: op = ($urandom_range(0, 1) != 0) ? OP_R : OP_I;
         endcase
         f3 = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) != 0) begin
            if (op == OP_LW || op == OP_SW) f3 = 3'd2;
            else if (op == OP_BEQ) f3 = 3'd0;
            else if (f3 inside {3'd1, 3'd3, 3'd4, 3'd5}) f3 = 3'd7;
         end
         abort_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 6)) : -1;
         add_instr(op, f3, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 3)), abort_at, -1, int'($urandom_range(1, 5)));
      end

      n_instr = 0;
      for (int i = 0; i < plan.size(); i++) begin
         @(negedge clk);
         rst          = plan[i].r;
         mem_ready_in = plan[i].rdy;
         zero_in      = plan[i].z;
         opcode_in    = plan[i].op;
         funct3_in    = plan[i].f3;
         funct7b5_in  = plan[i].f7;
         #1;
         if (plan[i].first) begin
            n_instr++;
            $display("[TB] instr %0d at step %0d: op=%b f3=%b f7b5=%0d legal=%0d", n_instr, i,
                     plan[i].op, plan[i].f3, plan[i].f7, legal_instr(plan[i].op, plan[i].f3));
         end
         got = {pc_write_out, ir_write_out, adr_src_out, mem_write_out, reg_write_out,
                result_src_out, alu_src_a_out, alu_src_b_out, imm_src_out, alu_ctrl_out, illegal_out};
         check_eq($sformatf("step%0d_state", i), {28'd0, state_out}, plan[i].st);
         check_eq($sformatf("step%0d_outputs", i), {15'd0, got}, {15'd0, exp_out(plan[i])});
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/friscv_mc_ctrl.md
Name: friscv_mc_ctrl

Overview:
Multi-cycle control FSM for the FRiscV datapath. It sequences fetch, decode, execute, memory and writeback over several cycles, so one memory port can serve both instructions and data. It drives every datapath mux select, the write strobes and the ALU control. It stalls on a memory ready handshake and traps on unsupported instructions.

Parameters:
STATE_W, 4, width of state_out debug port (fixed; 12 states)
ALU_CTRL_W, 3, width of alu_ctrl_out

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
opcode_in  in  7  instr[6:0] from instruction register
funct3_in  in  3  instr[14:12]
funct7b5_in  in  1  instr[30]
zero_in  in  1  ALU zero flag (combinational, current cycle)
mem_ready_in  in  1  memory access completes this cycle
pc_write_out  out  1  PC register load enable
ir_write_out  out  1  instruction/old-PC register load enable
adr_src_out  out  1  memory address: 0=PC, 1=result
mem_write_out  out  1  memory write strobe
reg_write_out  out  1  register file write enable
result_src_out  out  2  00=ALU-out reg, 01=data reg, 10=ALU result
alu_src_a_out  out  2  00=PC, 01=old PC, 10=rs1 data
alu_src_b_out  out  2  00=rs2 data, 01=imm, 10=const 4
imm_src_out  out  2  00=I, 01=S, 10=B, 11=J
alu_ctrl_out  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
illegal_out  out  1  sticky trap indicator
state_out  out  4  current state encoding

Behaviour:
- State register only; all outputs are a Moore decode of state, except FETCH/MEMREAD/MEMWRITE/BEQ strobes, which gate on mem_ready_in or zero_in. Unlisted outputs are 0.
- While rst=1: next state = FETCH(0); all strobes (pc_write, ir_write, mem_write, reg_write) forced 0; illegal_out=0. The first fetch happens the cycle after rst deasserts.
- Reset mid-operation aborts the instruction with no partial write. The datapath must not see a strobe in the reset cycle.
- FETCH(0): adr_src=0, src_a=00, src_b=10, add, result_src=10. If mem_ready_in: ir_write=1 and pc_write=1 in the same cycle, then DECODE. Otherwise hold FETCH with both strobes 0.
- DECODE(1): src_a=01, src_b=01, imm_src=10, add (precomputes branch target).
  - Next state by opcode: 0000011/0100011 -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1100011 -> BEQ, 1101111 -> JAL.
  - Goes to TRAP for any other opcode, for lw/sw funct3!=010, for beq funct3!=000, or for R/I funct3 not in {000,010,110,111}.
- MEMADR(2): src_a=10, src_b=01, add; imm_src=00 for lw, 01 for sw. Next state: MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD(3): adr_src=1, result_src=00. Waits for mem_ready_in, then MEMWB.
- MEMWB(4): result_src=01, reg_write=1, then FETCH.
- MEMWRITE(5): adr_src=1, result_src=00, mem_write=1 every cycle in state. FETCH on mem_ready_in.
- EXECR(6): src_a=10, src_b=00, ALU decode, then ALUWB.
- EXECI(7): src_a=10, src_b=01, imm_src=00, ALU decode, then ALUWB.
- ALU decode by funct3:
  - 000 -> sub only if opcode R-type and funct7b5=1, else add (addi ignores funct7b5).
  - 010 -> slt; 110 -> or; 111 -> and.
- ALUWB(8): result_src=00, reg_write=1, then FETCH.
- BEQ(9): src_a=10, src_b=00, sub, result_src=00, pc_write=zero_in, then FETCH.
- JAL(10): src_a=01, src_b=10, add, result_src=00, pc_write=1, then ALUWB (writes rd=old PC+4).
- TRAP(11): all strobes 0, illegal_out=1. Held until rst.
- States 12-15 are unreachable; if entered, next state is TRAP.
- Cycle counts with zero wait states: lw 5, sw 4, R/I 4, beq 3, jal 4. Each mem_ready_in=0 cycle adds 1.

Test Plan:
- Reset then R-type: rst high 2 cycles, opcode 0110011, funct3 000, funct7b5 1, ready=1 -> states 0,1,6,8,0; alu_ctrl=001 in EXECR; reg_write=1 only in cycle 4.
- lw with stalls: opcode 0000011, funct3 010, ready low 2 cycles in FETCH and 3 in MEMREAD -> FETCH held 3 cycles with ir_write=0 until ready; MEMWB reg_write=1 with result_src=01; 10 cycles total.
- sw: opcode 0100011, funct3 010 -> MEMADR imm_src=01; mem_write=1 in MEMWRITE, adr_src=1; reg_write never asserted.
- beq taken/not taken: opcode 1100011, funct3 000, zero_in=1 -> pc_write=1 in BEQ; repeat with zero_in=0 -> pc_write=0; both return to FETCH after 3 cycles.
- jal: opcode 1101111 -> states 0,1,10,8; pc_write=1 in JAL with src_a=01, src_b=10; reg_write=1 in ALUWB.
- Illegal/reset: opcode 0001111 -> TRAP, illegal_out=1 held 20 cycles with no strobes. Then assert rst during MEMWRITE of a later sw -> next state FETCH, mem_write=0 in the reset cycle, illegal_out=0.
